// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline memory stage.
//   DATA_W    : width of pipeline data/address values
//   ADDR_W    : word-address width toward the SRAM controller
//   BASE_ADDR : byte address that maps to memory word 0
//   REG_W     : register-file index width
//   mem_state_t : memory-stage sequencing states
package arm_pkg;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 16;
  localparam int BASE_ADDR = 1024;
  localparam int REG_W     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
// Ports:
//   clk, rst           : clock, synchronous active-low reset
//   load               : capture the d_* fields this edge
//   bubble             : when loading, insert an empty slot instead of d_*
//   d_*                : next values for the write-back fields
//   valid_out .. mem_read_value : registered write-back fields
module mem_wb_reg
  import arm_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             bubble,
  input  logic             d_valid,
  input  logic             d_wb_en,
  input  logic             d_mem_r_en,
  input  logic [REG_W-1:0] d_dest,
  input  logic [WIDTH-1:0] d_alu,
  input  logic [WIDTH-1:0] d_rdata,
  output logic             valid_out,
  output logic             wb_en,
  output logic             mem_r_en_out,
  output logic [REG_W-1:0] dest,
  output logic [WIDTH-1:0] alu_result_out,
  output logic [WIDTH-1:0] mem_read_value
);

  always_ff @(posedge clk) begin
    if (!rst || (load && bubble)) begin
      valid_out      <= 1'b0;
      wb_en          <= 1'b0;
      mem_r_en_out   <= 1'b0;
      dest           <= '0;
      alu_result_out <= '0;
      mem_read_value <= '0;
    end else if (load) begin
      valid_out      <= d_valid;
      wb_en          <= d_wb_en;
      mem_r_en_out   <= d_mem_r_en;
      dest           <= d_dest;
      alu_result_out <= d_alu;
      mem_read_value <= d_rdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage ARM pipeline with integrated MEM/WB
// register.
// Ports:
//   clk, rst                       : clock, synchronous active-low reset
//   valid_in, MEM_R_EN, MEM_W_EN,
//   WB_EN_in, Dest_in, ALU_result,
//   Val_Rm                         : instruction from the EXE/MEM register
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_ack, mem_rdata  : SRAM controller request/ack port
//   freeze                         : stall for upstream registers and PC
//   valid_out, WB_EN, MEM_R_EN_out,
//   Dest, ALU_result_out,
//   Mem_read_value                 : registered write-back fields
//   state                          : current sequencing state (debug)
//
// Handshake: a request is raised with mem_req=1 and mem_we/mem_addr/mem_wdata
// held stable until the controller returns a single-cycle mem_ack (read data
// valid in that same cycle); mem_req drops at the edge that samples mem_ack.
// mem_ack is only honoured while a request is outstanding.
module mem_stage
  import arm_pkg::*;
#(
  parameter int DATA_W    = arm_pkg::DATA_W,
  parameter int ADDR_W    = arm_pkg::ADDR_W,
  parameter int BASE_ADDR = arm_pkg::BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic              WB_EN_in,
  input  logic [REG_W-1:0]  Dest_in,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [DATA_W-1:0] Val_Rm,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              freeze,
  output logic              valid_out,
  output logic              WB_EN,
  output logic              MEM_R_EN_out,
  output logic [REG_W-1:0]  Dest,
  output logic [DATA_W-1:0] ALU_result_out,
  output logic [DATA_W-1:0] Mem_read_value,
  output mem_state_t        state
);

  mem_state_t        state_next;
  logic              mem_op;
  logic [ADDR_W-1:0] addr_word;
  logic [DATA_W-1:0] rdata_q;

  logic              wb_load;
  logic              wb_bubble;
  logic              d_valid;
  logic              d_wb_en;
  logic              d_mem_r_en;
  logic [DATA_W-1:0] d_rdata;

  assign mem_op = valid_in & (MEM_R_EN | MEM_W_EN);

  // Rebase to memory word 0 and drop the byte offset; addresses below the
  // base simply wrap within the word-address space.
  assign addr_word = ADDR_W'((ALU_result - DATA_W'(BASE_ADDR)) >> 2);

  always_comb begin
    state_next = state;
    freeze     = 1'b0;
    wb_load    = 1'b0;
    wb_bubble  = 1'b0;
    d_valid    = 1'b0;
    d_wb_en    = 1'b0;
    d_mem_r_en = 1'b0;
    d_rdata    = '0;
    case (state)
      IDLE: begin
        freeze  = mem_op;
        wb_load = 1'b1;
        if (mem_op) begin
          wb_bubble  = 1'b1;
          state_next = ACCESS;
        end else begin
          d_valid = valid_in;
          d_wb_en = WB_EN_in & valid_in;
        end
      end
      ACCESS: begin
        freeze = 1'b1;
        if (mem_ack) state_next = DONE;
      end
      DONE: begin
        // The instruction is still presented this cycle; retire it and return
        // to IDLE so it is not issued a second time.
        wb_load    = 1'b1;
        d_valid    = 1'b1;
        d_wb_en    = WB_EN_in;
        d_mem_r_en = MEM_R_EN & ~MEM_W_EN;
        d_rdata    = rdata_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (mem_op) begin
            mem_req   <= 1'b1;
            mem_we    <= MEM_W_EN;
            mem_addr  <= addr_word;
            mem_wdata <= Val_Rm;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            rdata_q <= mem_we ? '0 : mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  mem_wb_reg #(.WIDTH(DATA_W)) u_mem_wb_reg (
    .clk            (clk),
    .rst            (rst),
    .load           (wb_load),
    .bubble         (wb_bubble),
    .d_valid        (d_valid),
    .d_wb_en        (d_wb_en),
    .d_mem_r_en     (d_mem_r_en),
    .d_dest         (Dest_in),
    .d_alu          (ALU_result),
    .d_rdata        (d_rdata),
    .valid_out      (valid_out),
    .wb_en          (WB_EN),
    .mem_r_en_out   (MEM_R_EN_out),
    .dest           (Dest),
    .alu_result_out (ALU_result_out),
    .mem_read_value (Mem_read_value)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed instructions, an SRAM responder with
// configurable ack delay, and in-order scoreboards for write-back records and
// memory requests.
module tb_mem_stage;
  import arm_pkg::*;

  localparam int DW = 32;
  localparam int AW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          valid_in = 1'b0;
  logic          MEM_R_EN = 1'b0;
  logic          MEM_W_EN = 1'b0;
  logic          WB_EN_in = 1'b0;
  logic [3:0]    Dest_in = '0;
  logic [DW-1:0] ALU_result = '0;
  logic [DW-1:0] Val_Rm = '0;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          freeze;
  logic          valid_out;
  logic          WB_EN;
  logic          MEM_R_EN_out;
  logic [3:0]    Dest;
  logic [DW-1:0] ALU_result_out;
  logic [DW-1:0] Mem_read_value;
  mem_state_t    state;

  mem_stage #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(1024)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN), .WB_EN_in(WB_EN_in), .Dest_in(Dest_in),
    .ALU_result(ALU_result), .Val_Rm(Val_Rm), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .freeze(freeze),
    .valid_out(valid_out), .WB_EN(WB_EN), .MEM_R_EN_out(MEM_R_EN_out),
    .Dest(Dest), .ALU_result_out(ALU_result_out),
    .Mem_read_value(Mem_read_value), .state(state)
  );

  // ---------------- checking helpers ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: byte address -> word address relative to the memory base.
  function automatic logic [AW-1:0] word_addr(input logic [DW-1:0] byte_addr);
    logic [DW-1:0] words;
    words = (byte_addr - 32'd1024) / 4;
    return AW'(words);
  endfunction

  // Expected write-back records {wb_en, mem_r_en, dest, alu, rdata}, in order.
  logic [69:0] exp_q[$];
  // Expected memory requests {we, addr, wdata}, in order.
  logic [48:0] req_q[$];

  // ---------------- SRAM responder ----------------
  int          ack_delay = 0;   // 0 = never acknowledge
  logic [DW-1:0] ack_data = '0;
  bit          spur = 1'b0;     // pulse ack with no request outstanding
  int          wait_cnt = 0;

  always @(negedge clk) begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h5A5A_5A5A;
    if (rst && mem_req) begin
      wait_cnt++;
      if (ack_delay != 0 && wait_cnt == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = ack_data;
      end
    end else begin
      wait_cnt = 0;
      if (spur) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  // ---------------- scoreboards ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (valid_out) begin
        if (exp_q.size() == 0) chk("wb_unexpected_valid", valid_out, 0);
        else chk("wb_rec", {WB_EN, MEM_R_EN_out, Dest, ALU_result_out, Mem_read_value},
                 exp_q.pop_front());
      end else begin
        chk("wb_en_on_bubble", WB_EN, 0);
      end
    end
  end

  logic        prev_req = 1'b0;
  logic [48:0] cur_req = '0;
  int          req_trains = 0;

  always @(negedge clk) begin
    if (rst && mem_req) begin
      if (!prev_req) begin
        req_trains++;
        if (req_q.size() == 0) chk("req_unexpected", mem_req, 0);
        else cur_req = req_q.pop_front();
      end
      chk("req_fields", {mem_we, mem_addr, mem_wdata}, cur_req);
    end
    prev_req = mem_req;
  end

  // ---------------- driver ----------------
  // Presents one instruction, holds it while frozen, returns at the negedge
  // after the instruction was consumed. frz = cycles freeze was seen high.
  task automatic issue(input logic v, input logic r, input logic w, input logic wb,
                       input logic [3:0] d, input logic [DW-1:0] alu,
                       input logic [DW-1:0] rm, input int dly,
                       input logic [DW-1:0] rd, output int frz);
    logic is_mem;
    logic is_load;
    is_mem  = v & (r | w);
    is_load = r & ~w;
    valid_in = v; MEM_R_EN = r; MEM_W_EN = w; WB_EN_in = wb;
    Dest_in = d; ALU_result = alu; Val_Rm = rm;
    ack_delay = dly; ack_data = rd;
    if (is_mem) req_q.push_back({w, word_addr(alu), rm});
    if (v) exp_q.push_back({wb, is_mem & is_load, d, alu,
                            (is_mem && is_load) ? rd : 32'h0});
    frz = 0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (!freeze) break;
      frz++;
      @(negedge clk);
    end
    if (frz >= 64) chk("freeze_timeout", freeze, 0);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; WB_EN_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int frz;
    int t0;

    // model pins
    chk("model_addr_1032", word_addr(32'd1032), 16'd2);
    chk("model_addr_1024", word_addr(32'd1024), 16'd0);
    chk("model_addr_1020", word_addr(32'd1020), 16'hFFFF);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_freeze", freeze, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_wb_en", WB_EN, 0);
    chk("rst_mem_r_en_out", MEM_R_EN_out, 0);
    chk("rst_outs", {Dest, ALU_result_out, Mem_read_value}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_state", state, IDLE);
    rst = 1'b1;
    idle(1);

    // pass-through
    issue(1, 0, 0, 1, 4'd3, 32'd5, 32'h0, 0, 32'h0, frz);
    chk("pt_freeze_cycles", frz, 0);
    chk("pt_valid_out", valid_out, 1);
    chk("pt_wb_en", WB_EN, 1);
    chk("pt_dest", Dest, 3);
    chk("pt_alu", ALU_result_out, 5);

    // bubble with WB_EN_in high
    valid_in = 1'b0; WB_EN_in = 1'b1; ALU_result = 32'd9;
    @(negedge clk);
    chk("bubble_valid_out", valid_out, 0);
    chk("bubble_wb_en", WB_EN, 0);

    // load, ack in first ACCESS cycle
    issue(1, 1, 0, 1, 4'd5, 32'd1032, 32'h0, 1, 32'hDEADBEEF, frz);
    chk("ld_freeze_cycles", frz, 2);
    chk("ld_rdata", Mem_read_value, 32'hDEADBEEF);
    chk("ld_mem_r_en_out", MEM_R_EN_out, 1);
    chk("ld_mem_addr", mem_addr, 2);
    chk("ld_mem_we", mem_we, 0);

    // store, ack in fifth ACCESS cycle
    issue(1, 0, 1, 0, 4'd7, 32'd1024, 32'h12345678, 5, 32'hFFFF0000, frz);
    chk("st_freeze_cycles", frz, 6);
    chk("st_valid_out", valid_out, 1);
    chk("st_wb_en", WB_EN, 0);
    chk("st_rdata", Mem_read_value, 0);
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_addr", mem_addr, 0);
    chk("st_mem_wdata", mem_wdata, 32'h12345678);

    // back-to-back load then store (store has both enables: store wins)
    t0 = req_trains;
    issue(1, 1, 0, 1, 4'd8, 32'd1036, 32'h0, 2, 32'hCAFEF00D, frz);
    chk("b2b_ld_freeze", frz, 3);
    issue(1, 1, 1, 1, 4'd9, 32'd1041, 32'h0BADF00D, 1, 32'h11111111, frz);
    chk("b2b_st_freeze", frz, 2);
    chk("b2b_store_wins_r_en", MEM_R_EN_out, 0);
    chk("b2b_store_rdata", Mem_read_value, 0);
    chk("b2b_mem_addr", mem_addr, 16'd4);
    idle(2);
    chk("b2b_req_trains", req_trains - t0, 2);

    // spurious ack in IDLE, then wrapped address
    spur = 1'b1;
    idle(2);
    spur = 1'b0;
    chk("spur_mem_req", mem_req, 0);
    chk("spur_valid_out", valid_out, 0);
    issue(1, 1, 0, 1, 4'd2, 32'd1020, 32'h0, 1, 32'h0F0F0F0F, frz);
    chk("wrap_mem_addr", mem_addr, 16'hFFFF);
    chk("wrap_rdata", Mem_read_value, 32'h0F0F0F0F);

    // reset during ACCESS (never acknowledged)
    valid_in = 1'b1; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; WB_EN_in = 1'b1;
    Dest_in = 4'd6; ALU_result = 32'd1028; Val_Rm = 32'h0;
    ack_delay = 0;
    req_q.push_back({1'b0, word_addr(32'd1028), 32'h0});
    repeat (3) @(negedge clk);
    chk("mid_state_access", state, ACCESS);
    chk("mid_mem_req", mem_req, 1);
    rst = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_freeze", freeze, 0);
    chk("mid_rst_valid_out", valid_out, 0);
    chk("mid_rst_state", state, IDLE);
    rst = 1'b1;
    spur = 1'b1;
    idle(3);
    spur = 1'b0;
    chk("post_rst_valid_out", valid_out, 0);
    chk("post_rst_mem_req", mem_req, 0);

    idle(2);
    chk("wb_queue_drained", exp_q.size(), 0);
    chk("req_queue_drained", req_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage in the 5-stage ARM pipeline.
- Consumes the execute result (ALU_result as address, Val_Rm as store data) and the MEM/WB control bits.
- Performs loads and stores through a req/ack handshake to the external SRAM controller, stalling the pipeline via freeze while an access is outstanding.
- Registers its results into the write-back stage (integrated MEM/WB register).

Parameters:
- DATA_W, 32, data and address width of pipeline values.
- ADDR_W, 16, word-address width presented to the SRAM controller.
- BASE_ADDR, 1024, byte address mapped to memory word 0.

Ports:
- clk  in  1  pipeline clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- valid_in  in  1  EXE/MEM register holds a live instruction.
- MEM_R_EN  in  1  instruction is a load.
- MEM_W_EN  in  1  instruction is a store.
- WB_EN_in  in  1  instruction writes the register file.
- Dest_in  in  4  destination register.
- ALU_result  in  DATA_W  effective byte address, or arithmetic result.
- Val_Rm  in  DATA_W  store data.
- mem_req  out  1  access request to SRAM controller.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  DATA_W  write data.
- mem_ack  in  1  one-cycle completion pulse from controller.
- mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle.
- freeze  out  1  stall request to all upstream pipeline registers and the PC.
- valid_out  out  1  WB register holds a live instruction.
- WB_EN  out  1  registered write-enable to WB.
- MEM_R_EN_out  out  1  registered load flag; WB uses it as the mux select.
- Dest  out  4  registered destination.
- ALU_result_out  out  DATA_W  registered ALU result.
- Mem_read_value  out  DATA_W  registered load data.

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE.
  - mem_req, mem_we, freeze, valid_out, WB_EN, MEM_R_EN_out = 0.
  - Dest, ALU_result_out, Mem_read_value, mem_addr, mem_wdata = 0.
  - Reset overrides everything, including mid-access: mem_req drops at the next edge and any pending mem_ack is ignored.
- mem_op = valid_in & (MEM_R_EN | MEM_W_EN).
- If both MEM_R_EN and MEM_W_EN are set, the store wins: mem_we=1 and MEM_R_EN_out=0.
- Address rules:
  - mem_addr = ((ALU_result - BASE_ADDR) >> 2) truncated to ADDR_W.
  - Byte offset bits [1:0] are ignored.
  - Addresses below BASE_ADDR wrap modulo 2^ADDR_W; no fault is raised.
- State IDLE:
  - freeze = mem_op, combinational, so the stall is asserted in the same cycle the instruction is seen.
  - If mem_op: latch mem_addr, mem_we and mem_wdata=Val_Rm; set mem_req=1 at the edge; go to ACCESS. The output register loads a bubble (valid_out=0, WB_EN=0).
  - Otherwise, pass through: at the edge the output register loads valid_in, WB_EN_in&valid_in, MEM_R_EN=0, Dest_in, ALU_result and Mem_read_value=0. Latency is 1 cycle.
- State ACCESS:
  - freeze=1. mem_req=1; mem_addr, mem_we and mem_wdata are held stable.
  - On mem_ack=1: capture mem_rdata (reads only; 0 for writes), drop mem_req at the edge, go to DONE.
  - Waits indefinitely with no timeout. An ack in the first ACCESS cycle is legal.
- State DONE:
  - freeze=0, so the upstream register advances at this edge.
  - The output register loads valid_out=1, WB_EN=WB_EN_in, MEM_R_EN_out, Dest_in, ALU_result and the captured read data.
  - Next state is IDLE. DONE exists to prevent re-issuing the still-present instruction.
- mem_ack in IDLE or DONE is ignored.
- Minimum memory-op occupancy is 3 cycles (IDLE, ACCESS, DONE), with freeze high for 2. Back-to-back memory ops re-enter ACCESS from the IDLE cycle that follows DONE.
- valid_in=0 in IDLE produces a bubble with no request.

Decomposition:
- Shared package arm_pkg:
  - DATA_W, BASE_ADDR.
  - mem_state_t enum {IDLE, ACCESS, DONE}.
  - The 4-bit register-index width.
- One sub-module, mem_wb_reg: the output pipeline register. It has clk, rst, a load-enable and a bubble input, and holds all *_out fields.

Test Plan:
1. Reset mid-access: rst=0 during ACCESS -> next cycle mem_req=0, freeze=0, valid_out=0, state IDLE; a later mem_ack produces no output.
2. Non-memory pass-through: ALU_result=0x0000_0005, Dest_in=3, WB_EN_in=1 -> next cycle valid_out=1, WB_EN=1, Dest=3, ALU_result_out=5, freeze never high.
3. Load with 0-wait ack:
   - Stimulus: MEM_R_EN=1, ALU_result=1032, ack with mem_rdata=0xDEADBEEF in the first ACCESS cycle.
   - Response: mem_addr=2, mem_we=0, freeze high for exactly 2 cycles; after DONE, Mem_read_value=0xDEADBEEF, MEM_R_EN_out=1.
4. Store with 5-cycle ack delay:
   - Stimulus: MEM_W_EN=1, ALU_result=1024, Val_Rm=0x12345678.
   - Response: mem_we=1, mem_addr=0, mem_wdata=0x12345678 held stable all 5 cycles; freeze high for 6 cycles; WB_EN=0 on output.
5. Back-to-back load then store: both complete in order, each issues exactly one mem_req pulse train, and no duplicate request is issued from DONE.
6. Spurious mem_ack while in IDLE, plus an address of 1020: the ack is ignored, and the wrapped mem_addr=0xFFFF is issued.
